// File: rtl/definitions_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | definitions_pkg : shared types/constants for the Gaussian stage     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package definitions_pkg;

  localparam int GW_WIN_BYTES = 9;
  localparam int GW_PIX_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } gw_state_t;

endpackage
`default_nettype wire

// File: rtl/gaussian_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gaussian_line_buffer : one image line, comb read / sync write       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module gaussian_line_buffer
  import definitions_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [GW_PIX_W-1:0] wdata,
  output logic [GW_PIX_W-1:0] rdata
);

  logic [GW_PIX_W-1:0] r_mem [DEPTH];

  // Read returns the pre-write value so the top sees last line's pixel.
  assign rdata = r_mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gaussian_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gaussian_window_ctrl : line buffering, 3x3 windows, drain tracking  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module gaussian_window_ctrl
  import definitions_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           start,
  input  logic [GW_PIX_W-1:0]            pixel_in,
  input  logic                           pixel_in_valid,
  output logic                           pixel_in_ready,
  output logic [GW_WIN_BYTES*GW_PIX_W-1:0] gaussian_data_in,
  output logic                           gaussian_data_in_valid,
  input  logic                           gaussian_pixel_out_valid,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam int c_NWIN  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int c_OUT_W = $clog2(c_NWIN + 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_OUT_W-1:0] c_OUT_LAST = c_OUT_W'(c_NWIN);

  gw_state_t r_state, w_next;
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [c_OUT_W-1:0] r_out;
  logic [2:0][GW_PIX_W-1:0] r_col_m1, r_col_m2, w_cur;
  logic [GW_PIX_W-1:0] w_lb0_rd, w_lb1_rd;
  logic [GW_WIN_BYTES*GW_PIX_W-1:0] w_window, r_data;
  logic r_data_valid;
  logic w_accept, w_last, w_emit, w_count;

  assign w_accept = pixel_in_valid && pixel_in_ready;
  assign w_last   = w_accept && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
  assign w_emit   = w_accept && (r_col >= c_COL_W'(2)) && (r_row >= c_ROW_W'(2));
  assign w_count  = gaussian_pixel_out_valid && (r_state == ACTIVE || r_state == DRAIN)
                    && (r_out != c_OUT_LAST);

  gaussian_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(c_COL_W)) u_lb0 (
    .clk   (clk),
    .we    (w_accept),
    .addr  (r_col),
    .wdata (pixel_in),
    .rdata (w_lb0_rd)
  );

  gaussian_line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(c_COL_W)) u_lb1 (
    .clk   (clk),
    .we    (w_accept),
    .addr  (r_col),
    .wdata (w_lb0_rd),
    .rdata (w_lb1_rd)
  );

  // Index 0 is the oldest line (row-2), index 2 the incoming pixel.
  assign w_cur = {pixel_in, w_lb0_rd, w_lb1_rd};

  always_comb begin
    w_window = '0;
    for (int r = 0; r < 3; r++) begin
      w_window[GW_PIX_W*(3*r)     +: GW_PIX_W] = r_col_m2[r];
      w_window[GW_PIX_W*(3*r + 1) +: GW_PIX_W] = r_col_m1[r];
      w_window[GW_PIX_W*(3*r + 2) +: GW_PIX_W] = w_cur[r];
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = ACTIVE;
      ACTIVE:  if (w_last) w_next = DRAIN;
      DRAIN:   if (r_out == c_OUT_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pixel_in_ready = 1'b0;
    busy           = 1'b0;
    frame_done     = 1'b0;
    unique case (r_state)
      ACTIVE:  begin pixel_in_ready = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out        <= '0;
      r_col_m1     <= '0;
      r_col_m2     <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_emit;
      if (w_emit) begin
        r_data <= w_window;
      end
      if (w_accept) begin
        r_col_m2 <= r_col_m1;
        r_col_m1 <= w_cur;
      end
      if (r_state == IDLE && start) begin
        r_col <= '0;
        r_row <= '0;
        r_out <= '0;
      end else begin
        if (w_accept) begin
          if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
          end else begin
            r_col <= r_col + c_COL_W'(1);
          end
        end
        if (w_count) begin
          r_out <= r_out + c_OUT_W'(1);
        end
      end
    end
  end

  assign gaussian_data_in       = r_data;
  assign gaussian_data_in_valid = r_data_valid;

endmodule
`default_nettype wire
